win_scanner: RTL

WIN_SCANNER -- requirements
Module: win_scanner

---
 rtl/win_scanner_if.sv | 25 ++
 rtl/win_scanner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/win_scanner_if.sv
// Board read bus between the win scanner and the board storage.
// The scanner drives a cell address with rd_en; the board answers one cycle later.
interface win_scanner_if #(
    parameter int RW = 3,
    parameter int CW = 3
);
    logic          rd_en;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [1:0]    rd_data;

    modport master (
        output rd_en,
        output rd_row,
        output rd_col,
        input  rd_data
    );

    modport slave (
        input  rd_en,
        input  rd_row,
        input  rd_col,
        output rd_data
    );
endinterface

// File: rtl/win_scanner.sv
// Connect-N win scanner: after a move, walks outward from the played cell in
// the eight directions (paired into four axes) and reports whether the mover
// now owns a run of WIN_LEN cells. The move cell itself is never read; it is
// counted as the first piece of every axis run.
module win_scanner #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [RW-1:0] move_row,
    input  logic [CW-1:0] move_col,
    input  logic [1:0]    player,
    win_scanner_if.master rd_bus,
    output logic          busy,
    output logic          done,
    output logic          win,
    output logic [1:0]    winner,
    output logic [1:0]    win_axis,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col
);
    localparam int RUNW = $clog2(WIN_LEN + 1);

    // Coordinates carry one extra bit: stepping to -1 wraps to all ones and
    // stepping past the last row/column lands on ROWS/COLS, both of which
    // fail the unsigned "< ROWS/COLS" test.
    localparam logic [RW:0]     ROWS_X = (RW+1)'(ROWS);
    localparam logic [CW:0]     COLS_X = (CW+1)'(COLS);
    localparam logic [RUNW-1:0] WIN_X  = RUNW'(WIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_ISSUE,
        S_CMP,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      dir_reg, dir_next;
    logic [RUNW-1:0] run_reg, run_next;
    logic [RW:0]     mv_row_reg, mv_row_next;
    logic [CW:0]     mv_col_reg, mv_col_next;
    logic [RW:0]     cur_row_reg, cur_row_next;
    logic [CW:0]     cur_col_reg, cur_col_next;
    logic [1:0]      player_reg, player_next;
    logic            win_reg, win_next;
    logic [1:0]      winner_reg, winner_next;
    logic [1:0]      axis_reg, axis_next;
    logic [RW-1:0]   win_row_reg, win_row_next;
    logic [CW-1:0]   win_col_reg, win_col_next;

    logic [RW:0]     first_row, step_row_v;
    logic [CW:0]     first_col, step_col_v;
    logic            first_inb, step_inb;
    logic [RUNW-1:0] run_inc;
    logic            start_ok;
    logic            adv;

    // Row delta per direction: dirs 0,4,6 go up, 1,5,7 go down, 2,3 stay.
    function automatic logic [RW:0] step_row(input logic [RW:0] r, input logic [2:0] d);
        logic [RW:0] res;
        res = r;
        case (d)
            3'd0, 3'd4, 3'd6: res = r + (RW+1)'(1);
            3'd1, 3'd5, 3'd7: res = r - (RW+1)'(1);
            default:          res = r;
        endcase
        return res;
    endfunction

    // Column delta per direction: dirs 2,4,7 go right, 3,5,6 go left, 0,1 stay.
    function automatic logic [CW:0] step_col(input logic [CW:0] c, input logic [2:0] d);
        logic [CW:0] res;
        res = c;
        case (d)
            3'd2, 3'd4, 3'd7: res = c + (CW+1)'(1);
            3'd3, 3'd5, 3'd6: res = c - (CW+1)'(1);
            default:          res = c;
        endcase
        return res;
    endfunction

    assign first_row  = step_row(mv_row_reg, dir_reg);
    assign first_col  = step_col(mv_col_reg, dir_reg);
    assign first_inb  = (first_row < ROWS_X) && (first_col < COLS_X);
    assign step_row_v = step_row(cur_row_reg, dir_reg);
    assign step_col_v = step_col(cur_col_reg, dir_reg);
    assign step_inb   = (step_row_v < ROWS_X) && (step_col_v < COLS_X);
    assign run_inc    = run_reg + RUNW'(1);
    assign start_ok   = ({1'b0, move_row} < ROWS_X) && ({1'b0, move_col} < COLS_X)
                        && (player == 2'd1 || player == 2'd2);

    // Next-state and datapath updates for the scan FSM.
    always_comb begin
        state_next   = state_reg;
        dir_next     = dir_reg;
        run_next     = run_reg;
        mv_row_next  = mv_row_reg;
        mv_col_next  = mv_col_reg;
        cur_row_next = cur_row_reg;
        cur_col_next = cur_col_reg;
        player_next  = player_reg;
        win_next     = win_reg;
        winner_next  = winner_reg;
        axis_next    = axis_reg;
        win_row_next = win_row_reg;
        win_col_next = win_col_reg;
        adv          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    win_next     = 1'b0;
                    winner_next  = 2'd0;
                    axis_next    = 2'd0;
                    win_row_next = '0;
                    win_col_next = '0;
                    dir_next     = 3'd0;
                    run_next     = RUNW'(1);
                    mv_row_next  = {1'b0, move_row};
                    mv_col_next  = {1'b0, move_col};
                    player_next  = player;
                    state_next   = start_ok ? S_TURN : S_DONE;
                end
            end
            S_TURN: begin
                if (first_inb) begin
                    cur_row_next = first_row;
                    cur_col_next = first_col;
                    state_next   = S_ISSUE;
                end else begin
                    adv = 1'b1;
                end
            end
            S_ISSUE: begin
                state_next = S_CMP;
            end
            S_CMP: begin
                if (rd_bus.rd_data == player_reg) begin
                    run_next = run_inc;
                    if (run_inc == WIN_X) begin
                        win_next     = 1'b1;
                        winner_next  = player_reg;
                        axis_next    = dir_reg[2:1];
                        win_row_next = cur_row_reg[RW-1:0];
                        win_col_next = cur_col_reg[CW-1:0];
                        state_next   = S_DONE;
                    end else if (step_inb) begin
                        cur_row_next = step_row_v;
                        cur_col_next = step_col_v;
                        state_next   = S_ISSUE;
                    end else begin
                        adv = 1'b1;
                    end
                end else begin
                    adv = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Moving to the next direction; an even dir opens a fresh axis so the
        // run restarts at the move cell, an odd dir keeps the axis count.
        if (adv) begin
            if (dir_reg == 3'd7) begin
                state_next = S_DONE;
            end else begin
                dir_next   = dir_reg + 3'd1;
                state_next = S_TURN;
                if (dir_reg[0]) begin
                    run_next = RUNW'(1);
                end
            end
        end
    end

    // State and datapath registers; asynchronous reset aborts any scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            dir_reg     <= '0;
            run_reg     <= '0;
            mv_row_reg  <= '0;
            mv_col_reg  <= '0;
            cur_row_reg <= '0;
            cur_col_reg <= '0;
            player_reg  <= '0;
            win_reg     <= 1'b0;
            winner_reg  <= '0;
            axis_reg    <= '0;
            win_row_reg <= '0;
            win_col_reg <= '0;
        end else begin
            state_reg   <= state_next;
            dir_reg     <= dir_next;
            run_reg     <= run_next;
            mv_row_reg  <= mv_row_next;
            mv_col_reg  <= mv_col_next;
            cur_row_reg <= cur_row_next;
            cur_col_reg <= cur_col_next;
            player_reg  <= player_next;
            win_reg     <= win_next;
            winner_reg  <= winner_next;
            axis_reg    <= axis_next;
            win_row_reg <= win_row_next;
            win_col_reg <= win_col_next;
        end
    end

    assign busy          = (state_reg != S_IDLE);
    assign done          = (state_reg == S_DONE);
    assign rd_bus.rd_en  = (state_reg == S_ISSUE);
    assign rd_bus.rd_row = cur_row_reg[RW-1:0];
    assign rd_bus.rd_col = cur_col_reg[CW-1:0];
    assign win           = win_reg;
    assign winner        = winner_reg;
    assign win_axis      = axis_reg;
    assign win_row       = win_row_reg;
    assign win_col       = win_col_reg;
endmodule
